jenc_frame_ctrl: RTL and testbench

//  Per-frame sequencer for the JPEG encoder pipeline (dct_2d -> quant -> entropy -> bitpacker -> bytepacker).
//  - On a start request: latches image geometry, pulses the encoder reset, then opens the pixel gate for one frame.
//  - Waits for the compressed stream's final beat, then reports the byte count.
//  - Recovers via watchdog or abort so a stuck frame never wedges the camera path.
//  - Sits between the camera front end and the encoder's di/out handshakes, as an observer/gate only.
//

---
 rtl/jenc_pkg.sv | 21 ++
 rtl/jenc_byte_counter.sv | 49 ++++
 rtl/jenc_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_jenc_frame_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jenc_pkg.sv
// rtl/jenc_pkg.sv - shared types and helpers for the JPEG encoder frame controller
package jenc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        FLUSH,
        DONE,
        ABORT
    } jenc_ctrl_state_t;

    localparam int JENC_SIZE_W   = 20;
    localparam int JENC_BEAT_MAX = 16;

    // The bytepacker never emits more than 16 bytes per beat; anything larger is malformed.
    function automatic logic [4:0] jenc_clamp_bytes(input logic [4:0] bytes);
        return (bytes > 5'(JENC_BEAT_MAX)) ? 5'(JENC_BEAT_MAX) : bytes;
    endfunction

endpackage

// File: rtl/jenc_byte_counter.sv
// rtl/jenc_byte_counter.sv - saturating compressed-byte accumulator and flush watchdog
module jenc_byte_counter
    import jenc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   acc_i,
    input  logic [4:0]             bytes_i,
    input  logic                   wd_run_i,
    output logic [JENC_SIZE_W-1:0] sum_o,
    output logic                   wd_expired_o
);

    localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [JENC_SIZE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [JENC_SIZE_W:0]   sum_wide;
    logic [WW-1:0]          wd_cnt_q, wd_cnt_d;

    always_comb begin
        sum_wide = {1'b0, byte_cnt_q} + {{(JENC_SIZE_W - 4){1'b0}}, jenc_clamp_bytes(bytes_i)};
        sum_o    = sum_wide[JENC_SIZE_W] ? {JENC_SIZE_W{1'b1}} : sum_wide[JENC_SIZE_W-1:0];

        byte_cnt_d = byte_cnt_q;
        if (clear_i) begin
            byte_cnt_d = '0;
        end else if (acc_i) begin
            byte_cnt_d = sum_o;
        end

        // Watchdog only runs while flushing; any accepted output beat restarts it.
        wd_cnt_d = (!wd_run_i || acc_i) ? '0 : wd_cnt_q + WW'(1);
        wd_expired_o = wd_run_i && !acc_i && (wd_cnt_q == WW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
            wd_cnt_q   <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

endmodule

// File: rtl/jenc_frame_ctrl.sv
// rtl/jenc_frame_ctrl.sv - per-frame sequencer gating camera beats into the JPEG encoder
module jenc_frame_ctrl
    import jenc_pkg::*;
#(
    parameter int SENSOR_X_SIZE  = 1280,
    parameter int SENSOR_Y_SIZE  = 720,
    parameter int ENC_RST_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 2**20,
    localparam int XW = $clog2(SENSOR_X_SIZE),
    localparam int YW = $clog2(SENSOR_Y_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [XW-1:0]          x_size_m1,
    input  logic [YW-1:0]          y_size_m1,
    output logic [XW-1:0]          enc_x_size_m1,
    output logic [YW-1:0]          enc_y_size_m1,
    output logic                   enc_reset,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_hold,
    output logic                   enc_di_valid,
    input  logic                   enc_di_hold,
    input  logic                   enc_out_valid,
    input  logic                   enc_out_hold,
    input  logic [4:0]             enc_out_bytes,
    input  logic                   enc_out_tlast,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [JENC_SIZE_W-1:0] frame_size
);

    localparam int RW = (ENC_RST_CYCLES > 1) ? $clog2(ENC_RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_INIT = RW'(ENC_RST_CYCLES - 1);

    jenc_ctrl_state_t       state_q, state_d;
    logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic                   error_q, error_d;
    logic [JENC_SIZE_W-1:0] frame_size_q, frame_size_d;

    logic                   in_acc, out_acc, cnt_clear, cnt_acc, wd_run, wd_expired;
    logic [JENC_SIZE_W-1:0] cnt_sum;

    jenc_byte_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_byte_counter (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (cnt_clear),
        .acc_i       (cnt_acc),
        .bytes_i     (enc_out_bytes),
        .wd_run_i    (wd_run),
        .sum_o       (cnt_sum),
        .wd_expired_o(wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        error_d      = error_q;
        frame_size_d = frame_size_q;
        cnt_clear    = 1'b0;

        in_acc  = in_valid && !enc_di_hold && (state_q == RUN);
        out_acc = enc_out_valid && !enc_out_hold;
        cnt_acc = out_acc && (state_q == RUN || state_q == FLUSH);
        wd_run  = (state_q == FLUSH);

        enc_di_valid = (state_q == RUN) ? in_valid : 1'b0;
        in_hold      = (state_q == RUN) ? enc_di_hold : 1'b1;
        enc_reset    = (state_q == IDLE || state_q == ARM || state_q == ABORT);
        busy         = (state_q == ARM || state_q == RUN || state_q == FLUSH || state_q == ABORT);
        done         = (state_q == DONE);

        // Abort outranks everything, including a simultaneous start.
        if (abort) begin
            state_d   = ABORT;
            rst_cnt_d = RST_INIT;
            error_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d   = ARM;
                        rst_cnt_d = RST_INIT;
                        x_d       = x_size_m1;
                        y_d       = y_size_m1;
                        error_d   = 1'b0;
                        cnt_clear = 1'b1;
                    end
                end
                ARM: begin
                    if (rst_cnt_q == '0) state_d = RUN;
                    else                 rst_cnt_d = rst_cnt_q - RW'(1);
                end
                RUN: begin
                    if (out_acc && enc_out_tlast) begin
                        state_d      = DONE;
                        frame_size_d = cnt_sum;
                        if (!(in_acc && in_last)) error_d = 1'b1;
                    end else if (in_acc && in_last) begin
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    if (out_acc && enc_out_tlast) begin
                        state_d      = DONE;
                        frame_size_d = cnt_sum;
                    end else if (wd_expired) begin
                        state_d   = ABORT;
                        rst_cnt_d = RST_INIT;
                        error_d   = 1'b1;
                    end
                end
                ABORT: begin
                    if (rst_cnt_q == '0) state_d = IDLE;
                    else                 rst_cnt_d = rst_cnt_q - RW'(1);
                end
                default: state_d = IDLE;
            endcase
        end

        enc_x_size_m1 = x_q;
        enc_y_size_m1 = y_q;
        error         = error_q;
        frame_size    = frame_size_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rst_cnt_q    <= '0;
            x_q          <= '0;
            y_q          <= '0;
            error_q      <= 1'b0;
            frame_size_q <= '0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            error_q      <= error_d;
            frame_size_q <= frame_size_d;
        end
    end

endmodule

// File: tb/tb_jenc_frame_ctrl.sv
// tb/tb_jenc_frame_ctrl.sv - scoreboard bench for the JPEG encoder frame controller
module tb_jenc_frame_ctrl;

    localparam int XW   = 11;
    localparam int YW   = 10;
    localparam int TO   = 64;
    localparam int RSTC = 4;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [XW-1:0] x_size_m1, enc_x_size_m1;
    logic [YW-1:0] y_size_m1, enc_y_size_m1;
    logic          enc_reset, in_valid, in_last, in_hold, enc_di_valid, enc_di_hold;
    logic          enc_out_valid, enc_out_hold, enc_out_tlast;
    logic [4:0]    enc_out_bytes;
    logic          busy, done, error;
    logic [19:0]   frame_size;

    jenc_frame_ctrl #(
        .SENSOR_X_SIZE (1280),
        .SENSOR_Y_SIZE (720),
        .ENC_RST_CYCLES(RSTC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .x_size_m1    (x_size_m1),
        .y_size_m1    (y_size_m1),
        .enc_x_size_m1(enc_x_size_m1),
        .enc_y_size_m1(enc_y_size_m1),
        .enc_reset    (enc_reset),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_hold      (in_hold),
        .enc_di_valid (enc_di_valid),
        .enc_di_hold  (enc_di_hold),
        .enc_out_valid(enc_out_valid),
        .enc_out_hold (enc_out_hold),
        .enc_out_bytes(enc_out_bytes),
        .enc_out_tlast(enc_out_tlast),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .frame_size   (frame_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] size;
        logic        err;
    } frame_exp_t;

    frame_exp_t frame_q[$];
    int         beat_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         tx_idx   = 0;
    int         rx_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Encoder-side view of the di handshake: every beat the camera got accepted must arrive once, in order.
    always @(negedge clk) begin
        if (enc_di_valid && !enc_di_hold) begin
            chk("di_beat_queued", beat_q.size() > 0, 1);
            if (beat_q.size() > 0) chk("di_beat_order", rx_cnt, beat_q.pop_front());
            rx_cnt++;
        end
    end

    task automatic start_frame(input logic [XW-1:0] x, input logic [YW-1:0] y);
        int n;
        n = 0;
        x_size_m1 = x;
        y_size_m1 = y;
        start = 1'b1;
        cyc();
        start = 1'b0;
        x_size_m1 = '0;
        y_size_m1 = '0;
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_error_clr", error, 0);
        chk("latched_x", enc_x_size_m1, x);
        chk("latched_y", enc_y_size_m1, y);
        while (enc_reset && n < 20) begin
            n++;
            cyc();
        end
        chk("arm_reset_cycles", n, RSTC);
    endtask

    task automatic send_beats(input int n, input bit toggle_hold, input bit with_last);
        int sent;
        int guard;
        bit h;
        sent  = 0;
        guard = 0;
        h     = toggle_hold;
        while (sent < n && guard < 4 * n + 16) begin
            in_valid    = 1'b1;
            in_last     = with_last && (sent == n - 1);
            enc_di_hold = h;
            #1;
            chk("in_hold_mirror", in_hold, h);
            chk("di_valid_gate", enc_di_valid, 1);
            if (!h) begin
                beat_q.push_back(tx_idx);
                tx_idx++;
                sent++;
            end
            cyc();
            if (toggle_hold) h = ~h;
            guard++;
        end
        in_valid    = 1'b0;
        in_last     = 1'b0;
        enc_di_hold = 1'b0;
        chk("send_complete", sent, n);
    endtask

    task automatic out_beat(input logic [4:0] b, input bit last, input bit hold);
        enc_out_valid = 1'b1;
        enc_out_bytes = b;
        enc_out_tlast = last;
        enc_out_hold  = hold;
        cyc();
        enc_out_valid = 1'b0;
        enc_out_bytes = '0;
        enc_out_tlast = 1'b0;
        enc_out_hold  = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        frame_exp_t e;
        n = 0;
        while (!done && n < 100) begin
            n++;
            cyc();
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_sb_depth"}, frame_q.size(), 1);
        if (frame_q.size() > 0) begin
            e = frame_q.pop_front();
            chk({tag, "_frame_size"}, frame_size, e.size);
            chk({tag, "_error"}, error, e.err);
        end
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_enc_reset"}, enc_reset, 0);
    endtask

    task automatic wait_abort(input string tag);
        int m;
        m = 0;
        while (busy && m < 20) begin
            m++;
            cyc();
        end
        chk({tag, "_abort_cycles"}, m, RSTC);
        chk({tag, "_idle_enc_reset"}, enc_reset, 1);
        chk({tag, "_idle_error"}, error, 1);
        chk({tag, "_idle_done"}, done, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        x_size_m1 = '0; y_size_m1 = '0;
        in_valid = 1'b1; in_last = 1'b0; enc_di_hold = 1'b0;
        enc_out_valid = 1'b0; enc_out_hold = 1'b0; enc_out_bytes = '0; enc_out_tlast = 1'b0;
        cyc();
        cyc();
        chk("rst_enc_reset", enc_reset, 1);
        chk("rst_in_hold", in_hold, 1);
        chk("rst_di_valid", enc_di_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_frame_size", frame_size, 0);
        chk("rst_x", enc_x_size_m1, 0);
        chk("rst_y", enc_y_size_m1, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        cyc();

        // Nominal 16x8 frame
        start_frame(11'd15, 10'd7);
        frame_q.push_back('{20'd37, 1'b0});
        send_beats(16, 1'b0, 1'b1);
        in_valid = 1'b1;
        #1;
        chk("flush_in_hold", in_hold, 1);
        chk("flush_di_valid", enc_di_valid, 0);
        in_valid = 1'b0;
        out_beat(5'd16, 1'b0, 1'b0);
        out_beat(5'd16, 1'b0, 1'b0);
        out_beat(5'd5, 1'b1, 1'b0);
        wait_frame("nominal");
        chk("nominal_beats", rx_cnt, 16);

        // Toggling encoder backpressure, held and oversized output beats
        start_frame(11'd15, 10'd7);
        frame_q.push_back('{20'd19, 1'b0});
        send_beats(16, 1'b1, 1'b1);
        chk("bp_beats", rx_cnt, 32);
        out_beat(5'd7, 1'b0, 1'b1);
        out_beat(5'd20, 1'b0, 1'b0);
        out_beat(5'd3, 1'b1, 1'b0);
        wait_frame("bp");

        // Flush watchdog
        start_frame(11'd1, 10'd1);
        send_beats(1, 1'b0, 1'b1);
        n = 0;
        while (!enc_reset && n < 200) begin
            n++;
            cyc();
        end
        chk("timeout_flush_cycles", n, TO);
        chk("timeout_error", error, 1);
        chk("timeout_busy", busy, 1);
        wait_abort("timeout");
        chk("timeout_size_kept", frame_size, 19);

        // Abort and start together mid-RUN
        start_frame(11'd15, 10'd7);
        send_beats(3, 1'b0, 1'b0);
        x_size_m1 = 11'd99;
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        x_size_m1 = '0;
        chk("abort_busy", busy, 1);
        chk("abort_enc_reset", enc_reset, 1);
        chk("abort_error", error, 1);
        chk("abort_start_ignored_x", enc_x_size_m1, 15);
        wait_abort("abort_run");

        start_frame(11'd31, 10'd15);
        frame_q.push_back('{20'd10, 1'b0});
        send_beats(4, 1'b0, 1'b1);
        out_beat(5'd10, 1'b1, 1'b0);
        wait_frame("after_abort");

        // Back-to-back start from DONE; in_last and tlast in the same RUN cycle
        start_frame(11'd63, 10'd31);
        frame_q.push_back('{20'd9, 1'b0});
        in_valid = 1'b1; in_last = 1'b1;
        enc_out_valid = 1'b1; enc_out_bytes = 5'd9; enc_out_tlast = 1'b1;
        #1;
        beat_q.push_back(tx_idx);
        tx_idx++;
        cyc();
        in_valid = 1'b0; in_last = 1'b0;
        enc_out_valid = 1'b0; enc_out_bytes = '0; enc_out_tlast = 1'b0;
        wait_frame("last_and_tlast");

        // Early tlast while still in RUN
        start_frame(11'd63, 10'd31);
        send_beats(2, 1'b0, 1'b0);
        out_beat(5'd4, 1'b1, 1'b0);
        chk("early_tlast_done", done, 1);
        chk("early_tlast_error", error, 1);

        // Abort from DONE
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_done_busy", busy, 1);
        chk("abort_done_error", error, 1);
        chk("abort_done_done", done, 0);
        wait_abort("abort_done");

        // in_last without in_valid stays in RUN, then reset mid-frame
        start_frame(11'd15, 10'd7);
        in_last = 1'b1;
        cyc();
        cyc();
        chk("in_last_novalid_run", in_hold, 0);
        in_last = 1'b0;
        reset = 1'b1;
        cyc();
        chk("midrst_enc_reset", enc_reset, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_size", frame_size, 0);
        chk("midrst_x", enc_x_size_m1, 0);
        chk("midrst_error", error, 0);
        reset = 1'b0;
        cyc();

        // Byte count saturation: 70000 beats of 16 bytes
        start_frame(11'd1, 10'd1);
        frame_q.push_back('{20'hFFFFF, 1'b0});
        send_beats(1, 1'b0, 1'b1);
        enc_out_valid = 1'b1;
        enc_out_bytes = 5'd16;
        for (int i = 0; i < 69999; i++) cyc();
        enc_out_tlast = 1'b1;
        cyc();
        enc_out_valid = 1'b0; enc_out_bytes = '0; enc_out_tlast = 1'b0;
        wait_frame("saturate");

        chk("di_beats_drained", beat_q.size(), 0);
        chk("di_beats_total", rx_cnt, tx_idx);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
